// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - memory-stage to writeback-stage bundle and register-file write port
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 2
`endif

interface wb_stage_if #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
);
    logic                     wb_i_ce;
    logic [`OPCODE_WIDTH-1:0] wb_i_opcode;
    logic [FUNCT_WIDTH-1:0]   wb_i_funct3;
    logic [AWIDTH-1:0]        wb_i_rd_addr;
    logic [DWIDTH-1:0]        wb_i_rd_data;
    logic [DWIDTH-1:0]        wb_i_load_data;
    logic                     wb_i_rd_we;
    logic                     wb_i_flush;
    logic                     wb_i_rf_ready;
    logic                     wb_o_stall;
    logic                     wb_o_flush;
    logic                     wb_o_rf_we;
    logic [AWIDTH-1:0]        wb_o_rf_addr;
    logic [DWIDTH-1:0]        wb_o_rf_data;
    logic                     wb_o_fwd_valid;
    logic [AWIDTH-1:0]        wb_o_fwd_addr;
    logic [DWIDTH-1:0]        wb_o_fwd_data;
    logic                     wb_o_ce;
    logic [63:0]              wb_o_instret;

    modport master (
        output wb_i_ce, wb_i_opcode, wb_i_funct3, wb_i_rd_addr, wb_i_rd_data,
               wb_i_load_data, wb_i_rd_we, wb_i_flush, wb_i_rf_ready,
        input  wb_o_stall, wb_o_flush, wb_o_rf_we, wb_o_rf_addr, wb_o_rf_data,
               wb_o_fwd_valid, wb_o_fwd_addr, wb_o_fwd_data, wb_o_ce, wb_o_instret
    );

    modport slave (
        input  wb_i_ce, wb_i_opcode, wb_i_funct3, wb_i_rd_addr, wb_i_rd_data,
               wb_i_load_data, wb_i_rd_we, wb_i_flush, wb_i_rf_ready,
        output wb_o_stall, wb_o_flush, wb_o_rf_we, wb_o_rf_addr, wb_o_rf_data,
               wb_o_fwd_valid, wb_o_fwd_addr, wb_o_fwd_data, wb_o_ce, wb_o_instret
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage with 2-entry buffer, forwarding and retire counter
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 2
`endif

module wb_stage #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 5,
    parameter int FUNCT_WIDTH = 3
) (
    input logic       wb_clk,
    input logic       wb_rst,
    wb_stage_if.slave bus
);
    logic [1:0]             count_q;
    logic                   head_q;
    logic                   ent_we_q   [2];
    logic [AWIDTH-1:0]      ent_addr_q [2];
    logic [DWIDTH-1:0]      ent_data_q [2];
    logic [FUNCT_WIDTH-1:0] ent_f3_q   [2];
    logic                   ce_q;
    logic                   flush_q;
    logic [63:0]            instret_q;

    logic                   head_valid;
    logic                   in_we;
    logic [DWIDTH-1:0]      in_data;
    logic                   accept;
    logic                   retire;
    logic                   tail_idx;
    logic                   young_idx;
    logic                   unused_bits;

    // Entry formation: rd=x0 never writes, load results take the load path.
    always_comb begin
        in_we   = bus.wb_i_rd_we && (bus.wb_i_rd_addr != '0);
        in_data = bus.wb_i_opcode[`LOAD_WORD] ? bus.wb_i_load_data : bus.wb_i_rd_data;
    end

    // Buffer control: stall comes purely from the occupancy register.
    always_comb begin
        head_valid = (count_q != 2'd0);
        accept     = bus.wb_i_ce && (count_q != 2'd2) && !bus.wb_i_flush;
        retire     = head_valid && (!ent_we_q[head_q] || bus.wb_i_rf_ready);
        tail_idx   = head_q ^ count_q[0];
        young_idx  = head_q ^ (count_q == 2'd2);
    end

    // Register-file port and forwarding view of the buffered writes, youngest first.
    always_comb begin
        bus.wb_o_stall     = (count_q == 2'd2);
        bus.wb_o_rf_we     = head_valid && ent_we_q[head_q];
        bus.wb_o_rf_addr   = head_valid ? ent_addr_q[head_q] : '0;
        bus.wb_o_rf_data   = head_valid ? ent_data_q[head_q] : '0;
        bus.wb_o_fwd_valid = 1'b0;
        bus.wb_o_fwd_addr  = '0;
        bus.wb_o_fwd_data  = '0;
        if (count_q == 2'd2 && ent_we_q[young_idx]) begin
            bus.wb_o_fwd_valid = 1'b1;
            bus.wb_o_fwd_addr  = ent_addr_q[young_idx];
            bus.wb_o_fwd_data  = ent_data_q[young_idx];
        end else if (head_valid && ent_we_q[head_q]) begin
            bus.wb_o_fwd_valid = 1'b1;
            bus.wb_o_fwd_addr  = ent_addr_q[head_q];
            bus.wb_o_fwd_data  = ent_data_q[head_q];
        end
        bus.wb_o_ce      = ce_q;
        bus.wb_o_flush   = flush_q;
        bus.wb_o_instret = instret_q;
    end

    // funct3 travels with the entry but nothing downstream consumes it yet.
    assign unused_bits = ^{bus.wb_i_opcode, ent_f3_q[0], ent_f3_q[1]};

    // Buffer storage, pointers, retire pulse and instruction counter.
    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            count_q   <= 2'd0;
            head_q    <= 1'b0;
            ce_q      <= 1'b0;
            flush_q   <= 1'b0;
            instret_q <= 64'd0;
            for (int i = 0; i < 2; i++) begin
                ent_we_q[i]   <= 1'b0;
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_f3_q[i]   <= '0;
            end
        end else begin
            if (accept) begin
                ent_we_q[tail_idx]   <= in_we;
                ent_addr_q[tail_idx] <= bus.wb_i_rd_addr;
                ent_data_q[tail_idx] <= in_data;
                ent_f3_q[tail_idx]   <= bus.wb_i_funct3;
            end
            if (retire) begin
                head_q    <= ~head_q;
                instret_q <= instret_q + 64'd1;
            end
            case ({accept, retire})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            ce_q    <= retire;
            flush_q <= bus.wb_i_flush;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector bench for wb_stage
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 2
`endif

module tb_wb_stage;
    logic wb_clk = 1'b0;
    logic wb_rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 wb_clk = ~wb_clk;

    wb_stage_if #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3)) bus ();

    wb_stage #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    typedef struct {
        int unsigned ce, load, rd, rdd, ldd, we, flush, ready;
        int unsigned e_we, e_addr, e_data, e_stall, e_fv, e_fa, e_fd, e_ce, e_fl, e_ir;
    } vec_t;

    vec_t vt [19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic drive(input int unsigned ce, input int unsigned load, input int unsigned rd,
                         input int unsigned rdd, input int unsigned ldd, input int unsigned we,
                         input int unsigned flush, input int unsigned ready);
        bus.wb_i_ce        = ce[0];
        bus.wb_i_opcode    = load[0] ? `OPCODE_WIDTH'(1 << `LOAD_WORD) : `OPCODE_WIDTH'(1);
        bus.wb_i_funct3    = 3'd2;
        bus.wb_i_rd_addr   = rd[4:0];
        bus.wb_i_rd_data   = rdd;
        bus.wb_i_load_data = ldd;
        bus.wb_i_rd_we     = we[0];
        bus.wb_i_flush     = flush[0];
        bus.wb_i_rf_ready  = ready[0];
    endtask

    initial begin
        //        ce ld rd rd_data       load_data     we fl rdy | we ad data          st fv fa fd            ce fl instret
        vt[0]  = '{1, 1, 5, 'h1,         'hDEADBEEF,   1, 0, 1,    1, 5, 'hDEADBEEF,   0, 1, 5, 'hDEADBEEF,   0, 0, 0};
        vt[1]  = '{1, 0, 5, 'h1,         'hDEADBEEF,   1, 0, 1,    1, 5, 'h1,          0, 1, 5, 'h1,          1, 0, 1};
        vt[2]  = '{0, 0, 0, 0,           0,            0, 0, 1,    0, 0, 0,            0, 0, 0, 0,            1, 0, 2};
        vt[3]  = '{1, 0, 1, 'h11,        0,            1, 0, 0,    1, 1, 'h11,         0, 1, 1, 'h11,         0, 0, 2};
        vt[4]  = '{1, 0, 2, 'h22,        0,            1, 0, 0,    1, 1, 'h11,         1, 1, 2, 'h22,         0, 0, 2};
        vt[5]  = '{1, 0, 3, 'h33,        0,            1, 0, 1,    1, 2, 'h22,         0, 1, 2, 'h22,         1, 0, 3};
        vt[6]  = '{0, 0, 0, 0,           0,            0, 0, 1,    0, 0, 0,            0, 0, 0, 0,            1, 0, 4};
        vt[7]  = '{1, 0, 0, 'h77,        0,            1, 0, 0,    0, 0, 'h77,         0, 0, 0, 0,            0, 0, 4};
        vt[8]  = '{0, 0, 0, 0,           0,            0, 0, 0,    0, 0, 0,            0, 0, 0, 0,            1, 0, 5};
        vt[9]  = '{1, 0, 7, 'h99,        0,            0, 0, 0,    0, 7, 'h99,         0, 0, 0, 0,            0, 0, 5};
        vt[10] = '{0, 0, 0, 0,           0,            0, 0, 0,    0, 0, 0,            0, 0, 0, 0,            1, 0, 6};
        vt[11] = '{1, 0, 4, 'h44,        0,            1, 0, 0,    1, 4, 'h44,         0, 1, 4, 'h44,         0, 0, 6};
        vt[12] = '{1, 0, 6, 'h66,        0,            1, 1, 0,    1, 4, 'h44,         0, 1, 4, 'h44,         0, 1, 6};
        vt[13] = '{0, 0, 0, 0,           0,            0, 0, 1,    0, 0, 0,            0, 0, 0, 0,            1, 0, 7};
        vt[14] = '{1, 0, 8, 'h88,        0,            1, 0, 0,    1, 8, 'h88,         0, 1, 8, 'h88,         0, 0, 7};
        vt[15] = '{1, 0, 9, 'h99,        0,            0, 0, 0,    1, 8, 'h88,         1, 1, 8, 'h88,         0, 0, 7};
        vt[16] = '{0, 0, 0, 0,           0,            0, 0, 1,    0, 9, 'h99,         0, 0, 0, 0,            1, 0, 8};
        vt[17] = '{0, 0, 0, 0,           0,            0, 0, 0,    0, 0, 0,            0, 0, 0, 0,            1, 0, 9};
        vt[18] = '{0, 0, 0, 0,           0,            0, 0, 0,    0, 0, 0,            0, 0, 0, 0,            0, 0, 9};

        drive(1, 0, 3, 'h5, 0, 1, 1, 1);
        tick();
        tick();
        chk("rst stall",   64'(bus.wb_o_stall),     64'd0);
        chk("rst rf_we",   64'(bus.wb_o_rf_we),     64'd0);
        chk("rst rf_addr", 64'(bus.wb_o_rf_addr),   64'd0);
        chk("rst rf_data", 64'(bus.wb_o_rf_data),   64'd0);
        chk("rst fwd_v",   64'(bus.wb_o_fwd_valid), 64'd0);
        chk("rst fwd_a",   64'(bus.wb_o_fwd_addr),  64'd0);
        chk("rst fwd_d",   64'(bus.wb_o_fwd_data),  64'd0);
        chk("rst ce",      64'(bus.wb_o_ce),        64'd0);
        chk("rst flush",   64'(bus.wb_o_flush),     64'd0);
        chk("rst instret", bus.wb_o_instret,        64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        wb_rst = 1'b1;
        tick();

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].ce, vt[i].load, vt[i].rd, vt[i].rdd, vt[i].ldd, vt[i].we, vt[i].flush, vt[i].ready);
            tick();
            chk($sformatf("v%0d rf_we", i),   64'(bus.wb_o_rf_we),     64'(vt[i].e_we));
            chk($sformatf("v%0d rf_addr", i), 64'(bus.wb_o_rf_addr),   64'(vt[i].e_addr));
            chk($sformatf("v%0d rf_data", i), 64'(bus.wb_o_rf_data),   64'(vt[i].e_data));
            chk($sformatf("v%0d stall", i),   64'(bus.wb_o_stall),     64'(vt[i].e_stall));
            chk($sformatf("v%0d fwd_v", i),   64'(bus.wb_o_fwd_valid), 64'(vt[i].e_fv));
            chk($sformatf("v%0d fwd_a", i),   64'(bus.wb_o_fwd_addr),  64'(vt[i].e_fa));
            chk($sformatf("v%0d fwd_d", i),   64'(bus.wb_o_fwd_data),  64'(vt[i].e_fd));
            chk($sformatf("v%0d ce", i),      64'(bus.wb_o_ce),        64'(vt[i].e_ce));
            chk($sformatf("v%0d flush", i),   64'(bus.wb_o_flush),     64'(vt[i].e_fl));
            chk($sformatf("v%0d instret", i), bus.wb_o_instret,        64'(vt[i].e_ir));
        end

        drive(1, 0, 1, 'h11, 0, 1, 0, 0);
        tick();
        drive(1, 0, 2, 'h22, 0, 1, 0, 0);
        tick();
        chk("mid stall before rst", 64'(bus.wb_o_stall), 64'd1);
        drive(1, 0, 3, 'h33, 0, 1, 1, 1);
        wb_rst = 1'b0;
        tick();
        chk("mid rst stall",   64'(bus.wb_o_stall),     64'd0);
        chk("mid rst rf_we",   64'(bus.wb_o_rf_we),     64'd0);
        chk("mid rst instret", bus.wb_o_instret,        64'd0);
        chk("mid rst fwd_v",   64'(bus.wb_o_fwd_valid), 64'd0);
        chk("mid rst ce",      64'(bus.wb_o_ce),        64'd0);
        chk("mid rst flush",   64'(bus.wb_o_flush),     64'd0);
        wb_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap preload", bus.wb_o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 0, 0, 'h5, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap before retire", bus.wb_o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("wrap ce",      64'(bus.wb_o_ce), 64'd1);
        chk("wrap instret", bus.wb_o_instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
